// File: rtl/led_sequence_monitor.sv
// One-hot LED chaser checker: tracks position, counts laps, latches the first fault.
// Define LED_MON_STALL_CHECK_EN to build the hold counter and the stall fault (code 11).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for the pattern to start at 0x01; dark bus is fine
// S_TRACK | following the chase; pos_valid_o high
// S_FAULT | first fault latched in err_code_o; led_i ignored until clr_err_i
module led_sequence_monitor #(
   parameter int HOLD_MAX = 4,
   parameter int LAP_W    = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [7:0]       led_i,
   input  logic             clr_err_i,
   output logic [2:0]       pos_o,
   output logic             pos_valid_o,
   output logic [LAP_W-1:0] lap_cnt_o,
   output logic             err_o,
   output logic [1:0]       err_code_o
);

   if (HOLD_MAX < 1) begin : g_bad_hold_max
      $error("HOLD_MAX must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_TRACK = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   localparam logic [1:0] CODE_NONE   = 2'b00;
   localparam logic [1:0] CODE_MULTI  = 2'b01;
   localparam logic [1:0] CODE_STEP   = 2'b10;
   localparam logic [1:0] CODE_STALL  = 2'b11;

   state_t           state_q, state_d;
   logic [7:0]       prev_q, prev_d;
   logic [2:0]       pos_q, pos_d;
   logic [LAP_W-1:0] lap_q, lap_d;
   logic [1:0]       code_q, code_d;

`ifdef LED_MON_STALL_CHECK_EN
   localparam int HOLD_W = $clog2(HOLD_MAX + 1);
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              hold_full;
   // Compared before incrementing so hold never has to represent HOLD_MAX+1.
   assign hold_full = (hold_q >= HOLD_W'(HOLD_MAX));
`endif

   logic       led_zero;
   logic       led_onehot;
   logic       led_same;
   logic       led_next;
   logic [2:0] led_idx;

   assign led_zero   = (led_i == 8'h00);
   assign led_onehot = !led_zero && ((led_i & (led_i - 8'd1)) == 8'h00);
   assign led_same   = (led_i == prev_q);
   assign led_next   = (led_i == {prev_q[6:0], prev_q[7]});

   always_comb begin
      led_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (led_i[i]) led_idx = i[2:0];
      end
   end

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      pos_d   = pos_q;
      lap_d   = lap_q;
      code_d  = code_q;
`ifdef LED_MON_STALL_CHECK_EN
      hold_d  = hold_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!led_zero) begin
               if (!led_onehot) begin
                  state_d = S_FAULT;
                  code_d  = CODE_MULTI;
               end else if (led_i == 8'h01) begin
                  state_d = S_TRACK;
                  prev_d  = 8'h01;
                  pos_d   = 3'd0;
                  lap_d   = '0;
`ifdef LED_MON_STALL_CHECK_EN
                  hold_d  = HOLD_W'(1);
`endif
               end else begin
                  state_d = S_FAULT;
                  code_d  = CODE_STEP;
               end
            end
         end
         S_TRACK: begin
            if (!led_zero && !led_onehot) begin
               state_d = S_FAULT;
               code_d  = CODE_MULTI;
            end else if (led_zero) begin
               state_d = S_IDLE;
            end else if (led_same) begin
`ifdef LED_MON_STALL_CHECK_EN
               if (hold_full) begin
                  state_d = S_FAULT;
                  code_d  = CODE_STALL;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
`endif
            end else if (led_next) begin
               prev_d = led_i;
               pos_d  = led_idx;
`ifdef LED_MON_STALL_CHECK_EN
               hold_d = HOLD_W'(1);
`endif
               if (prev_q == 8'h80 && lap_q != '1) lap_d = lap_q + 1'b1;
            end else begin
               state_d = S_FAULT;
               code_d  = CODE_STEP;
            end
         end
         S_FAULT: begin
            if (clr_err_i) begin
               state_d = S_IDLE;
               code_d  = CODE_NONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            code_d  = CODE_NONE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         prev_q  <= 8'h00;
         pos_q   <= 3'd0;
         lap_q   <= '0;
         code_q  <= CODE_NONE;
`ifdef LED_MON_STALL_CHECK_EN
         hold_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         pos_q   <= pos_d;
         lap_q   <= lap_d;
         code_q  <= code_d;
`ifdef LED_MON_STALL_CHECK_EN
         hold_q  <= hold_d;
`endif
      end
   end

   assign pos_o       = pos_q;
   assign pos_valid_o = (state_q == S_TRACK);
   assign lap_cnt_o   = lap_q;
   assign err_o       = (state_q == S_FAULT);
   assign err_code_o  = code_q;

endmodule

// File: tb/tb_led_sequence_monitor.sv
// Self-checking bench for led_sequence_monitor: directed table, corner sequences, random vs reference model.
module tb_led_sequence_monitor;

   localparam int HOLD_MAX = 4;
   localparam int LAP_W    = 8;
   localparam int LAP_MAX  = (1 << LAP_W) - 1;
`ifdef LED_MON_STALL_CHECK_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [7:0]       led = 8'h00;
   logic             clr = 1'b0;
   logic [2:0]       pos;
   logic             pos_valid;
   logic [LAP_W-1:0] lap_cnt;
   logic             err;
   logic [1:0]       err_code;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   led_sequence_monitor #(.HOLD_MAX(HOLD_MAX), .LAP_W(LAP_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .led_i       (led),
      .clr_err_i   (clr),
      .pos_o       (pos),
      .pos_valid_o (pos_valid),
      .lap_cnt_o   (lap_cnt),
      .err_o       (err),
      .err_code_o  (err_code)
   );

   // Reference model: mode 0 idle, 1 tracking, 2 faulted; position kept as an index.
   int m_mode = 0;
   int m_pos  = 0;
   int m_hold = 0;
   int m_lap  = 0;
   int m_code = 0;

   function automatic logic [7:0] bit_of(input int idx);
      logic [7:0] one;
      one = 8'd1;
      return one << (idx % 8);
   endfunction

   task automatic model_step(input logic r, input logic c, input logic [7:0] l);
      int ones;
      ones = $countones(l);
      if (r) begin
         m_mode = 0; m_pos = 0; m_hold = 0; m_lap = 0; m_code = 0;
      end else if (m_mode == 0) begin
         if (ones > 1) begin
            m_mode = 2; m_code = 1;
         end else if (l == 8'h01) begin
            m_mode = 1; m_pos = 0; m_hold = 1; m_lap = 0;
         end else if (ones == 1) begin
            m_mode = 2; m_code = 2;
         end
      end else if (m_mode == 1) begin
         if (ones > 1) begin
            m_mode = 2; m_code = 1;
         end else if (ones == 0) begin
            m_mode = 0;
         end else if (l == bit_of(m_pos)) begin
            m_hold++;
            if (STALL_EN && m_hold > HOLD_MAX) begin
               m_mode = 2; m_code = 3;
            end
         end else if (l == bit_of(m_pos + 1)) begin
            if (m_pos == 7 && m_lap < LAP_MAX) m_lap++;
            m_pos  = (m_pos + 1) % 8;
            m_hold = 1;
         end else begin
            m_mode = 2; m_code = 2;
         end
      end else if (c) begin
         m_mode = 0; m_code = 0;
      end
   endtask

   task automatic drive(input logic r, input logic c, input logic [7:0] l);
      @(negedge clk);
      rst = r; clr = c; led = l;
      @(posedge clk);
      model_step(r, c, l);
      #1;
   endtask

   task automatic check(input string name, input logic [2:0] ep, input logic ev,
                        input logic [LAP_W-1:0] el, input logic ee, input logic [1:0] ec);
      n_checks++;
      if (pos !== ep || pos_valid !== ev || lap_cnt !== el || err !== ee || err_code !== ec) begin
         n_errors++;
         $display("FAIL %s: got pos=%0d valid=%0b lap=%0d err=%0b code=%0d, expected pos=%0d valid=%0b lap=%0d err=%0b code=%0d",
                  name, pos, pos_valid, lap_cnt, err, err_code, ep, ev, el, ee, ec);
      end
   endtask

   task automatic check_model(input string name);
      check(name, 3'(m_pos), m_mode == 1, LAP_W'(m_lap), m_mode == 2, 2'(m_code));
   endtask

   typedef struct {
      logic       r;
      logic       c;
      logic [7:0] l;
      logic [2:0] ep;
      logic       ev;
      logic [7:0] el;
      logic       ee;
      logic [1:0] ec;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic c, input logic [7:0] l, input logic [2:0] ep,
                               input logic ev, input logic [7:0] el, input logic ee, input logic [1:0] ec);
      vec_t v;
      v = '{r, c, l, ep, ev, el, ee, ec};
      vecs.push_back(v);
   endfunction

   initial begin
      // rst clr led     pos valid lap err code
      add(1, 0, 8'h00,   0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 0, 8'h00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) add(0, 0, bit_of(i), 3'(i), 1, 0, 0, 0);
      add(0, 0, 8'h01,   0, 1, 1, 0, 0);
      add(0, 0, 8'h02,   1, 1, 1, 0, 0);
      add(0, 0, 8'h08,   1, 0, 1, 1, 2);
      add(0, 0, 8'h01,   1, 0, 1, 1, 2);
      add(0, 1, 8'h01,   1, 0, 1, 0, 0);
      add(0, 0, 8'h01,   0, 1, 0, 0, 0);
      add(0, 0, 8'h02,   1, 1, 0, 0, 0);
      add(0, 0, 8'h03,   1, 0, 0, 1, 1);
      add(0, 1, 8'h00,   1, 0, 0, 0, 0);
      add(0, 0, 8'h08,   1, 0, 0, 1, 2);
      add(1, 1, 8'h08,   0, 0, 0, 0, 0);
      add(0, 0, 8'h01,   0, 1, 0, 0, 0);
      add(0, 0, 8'h02,   1, 1, 0, 0, 0);
      add(0, 0, 8'h00,   1, 0, 0, 0, 0);
      add(0, 0, 8'h01,   0, 1, 0, 0, 0);
      add(0, 0, 8'h02,   1, 1, 0, 0, 0);
      add(0, 0, 8'h04,   2, 1, 0, 0, 0);
      add(0, 0, 8'h10,   2, 0, 0, 1, 2);
      add(0, 0, 8'h00,   2, 0, 0, 1, 2);
      add(0, 1, 8'h00,   2, 0, 0, 0, 0);
      add(0, 0, 8'h01,   0, 1, 0, 0, 0);
      add(0, 0, 8'h02,   1, 1, 0, 0, 0);
      add(0, 0, 8'h04,   2, 1, 0, 0, 0);
      add(1, 0, 8'h20,   0, 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r, vecs[i].c, vecs[i].l);
         check($sformatf("table[%0d]", i), vecs[i].ep, vecs[i].ev, LAP_W'(vecs[i].el), vecs[i].ee, vecs[i].ec);
      end

      // Lap saturation over 300 laps, then restart from idle clears the count.
      drive(1, 0, 8'h00);
      drive(0, 0, 8'h01);
      for (int lap = 0; lap < 300; lap++) begin
         for (int i = 1; i <= 8; i++) begin
            drive(0, 0, bit_of(i));
            check_model("lap_run");
         end
         if (lap == 0) check("first_wrap", 0, 1, LAP_W'(1), 0, 0);
      end
      check("lap_saturated", 0, 1, LAP_W'(LAP_MAX), 0, 0);
      drive(0, 0, 8'h00);
      check("idle_keeps_lap", 0, 0, LAP_W'(LAP_MAX), 0, 0);
      drive(0, 0, 8'h01);
      check("restart_clears_lap", 0, 1, LAP_W'(0), 0, 0);

      // Hold of 0x02: HOLD_MAX cycles legal, one more faults only with the stall check built.
      for (int i = 0; i < HOLD_MAX; i++) begin
         drive(0, 0, 8'h02);
         check($sformatf("hold_%0d", i + 1), 1, 1, 0, 0, 0);
      end
      drive(0, 0, 8'h02);
      if (STALL_EN) begin
         check("stall_fault", 1, 0, 0, 1, 3);
         drive(0, 0, 8'h03);
         check("stall_code_sticky", 1, 0, 0, 1, 3);
      end else begin
         check("no_stall_fault", 1, 1, 0, 0, 0);
         for (int i = 0; i < 20; i++) drive(0, 0, 8'h02);
         check("long_hold_legal", 1, 1, 0, 0, 0);
      end

      // clr_err with 0x01 on the same edge goes idle only.
      drive(0, 0, 8'h10);
      drive(0, 1, 8'h01);
      check("clr_to_idle_only", 1, 0, 0, 0, 0);
      drive(0, 0, 8'h01);
      check("track_after_clr", 0, 1, 0, 0, 0);

      // Random walk against the reference model.
      drive(1, 0, 8'h00);
      for (int n = 0; n < 3000; n++) begin
         int         sel;
         logic [7:0] l;
         logic       c;
         logic       r;
         sel = $urandom_range(0, 99);
         if (sel < 55)      l = (m_mode == 1) ? bit_of(m_pos + 1) : 8'h01;
         else if (sel < 72) l = (m_mode == 1) ? bit_of(m_pos) : 8'h00;
         else if (sel < 80) l = 8'h00;
         else if (sel < 88) l = 8'($urandom);
         else               l = bit_of($urandom_range(0, 7));
         c = ($urandom_range(0, 9) == 0);
         r = ($urandom_range(0, 149) == 0);
         drive(r, c, l);
         check_model("random");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
